// File: rtl/operand_bus_arbiter.sv
// operand_bus_arbiter: round-robin arbiter sharing one registered ALU operand bus between 4 requesters
module operand_bus_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  output logic [1:0]         sel,
  output logic               busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, src_q, src_d, win, idx;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0] ack_q, ack_d, mreq;
  logic found, arb;
  // a requester acked this cycle is still showing its old req, so mask it out
  always_comb begin
    mreq = req & ~ack_q;
    win = ptr_q;
    idx = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && mreq[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    arb = |mreq && (state_q == IDLE || out_ready);
    state_d = arb ? HOLD : (state_q == HOLD && out_ready) ? IDLE : state_q;
    ptr_d = arb ? win : ptr_q;
    src_d = arb ? win : src_q;
    data_d = arb ? req_data[win*WIDTH +: WIDTH] : data_q;
    ack_d = arb ? 4'(1) << win : 4'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 2'd3;
      src_q <= 2'd0;
      data_q <= '0;
      ack_q <= 4'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      src_q <= src_d;
      data_q <= data_d;
      ack_q <= ack_d;
    end
  end
  assign out_valid = (state_q == HOLD);
  assign busy = out_valid;
  assign out_data = data_q;
  assign out_src = src_q;
  assign sel = src_q;
  assign req_ack = ack_q;
endmodule

// File: tb/tb_operand_bus_arbiter.sv
// tb_operand_bus_arbiter: scoreboard bench for operand_bus_arbiter with directed and random traffic
module tb_operand_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [31:0] req_data;
  logic [3:0] req_ack;
  logic out_valid, out_ready, busy;
  logic [7:0] out_data;
  logic [1:0] out_src, sel;
  int n_cmp = 0;
  int n_err = 0;
  int grants;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [1:0] s;
    logic [3:0] a;
  } exp_t;
  exp_t sb[$];

  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_src;
  logic [3:0] m_ack;
  int         m_ptr;

  operand_bus_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // predict the next-edge outputs from the current inputs, then compare after the edge
  task automatic step();
    logic [3:0] mreq;
    bit found;
    int w;
    exp_t e, g;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ack = 0; m_ptr = 3;
    end else begin
      mreq = req & ~m_ack;
      found = 0;
      w = 0;
      for (int k = 1; k <= 4; k++)
        if (!found && mreq[(m_ptr + k) % 4]) begin
          w = (m_ptr + k) % 4;
          found = 1;
        end
      if (found && (!m_valid || out_ready)) begin
        m_data = req_data[w*8 +: 8];
        m_src = 2'(w);
        m_ack = 4'(1) << w;
        m_ptr = w;
        m_valid = 1;
      end else begin
        m_ack = 0;
        if (m_valid && out_ready) m_valid = 0;
      end
    end
    e = '{v: m_valid, d: m_data, s: m_src, a: m_ack};
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("valid", 32'(out_valid), 32'(g.v));
    chk("busy", 32'(busy), 32'(g.v));
    chk("data", 32'(out_data), 32'(g.d));
    chk("src", 32'(out_src), 32'(g.s));
    chk("sel", 32'(sel), 32'(g.s));
    chk("ack", 32'(req_ack), 32'(g.a));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; req = 0; req_data = 0; out_ready = 0;
    @(negedge clk);
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    rst_n = 1;
    // 1: single transfer
    req = 4'b0001; req_data = 32'h0000_005A; out_ready = 1;
    step();
    chk("t1_data", 32'(out_data), 32'h5A);
    chk("t1_src", 32'(out_src), 0);
    chk("t1_ack", 32'(req_ack), 32'b0001);
    req = 0;
    step();
    chk("t1_idle", 32'(out_valid), 0);
    // 2: all requesting, full rotation with no gaps
    rst_n = 0; step(); rst_n = 1;
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_src", 32'(out_src), 32'(i % 4));
      chk("t2_data", 32'(out_data), 32'(8'h11 * (i % 4 + 1)));
      chk("t2_ack", 32'(req_ack), 32'(4'(1) << (i % 4)));
    end
    req = 0;
    step();
    // 3: backpressure holds the operand stable
    req = 4'b0100; req_data = 32'h007E_0000; out_ready = 0;
    step();
    chk("t3_ack0", 32'(req_ack), 32'b0100);
    req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_data", 32'(out_data), 32'h7E);
      chk("t3_src", 32'(out_src), 2);
      chk("t3_ack", 32'(req_ack), 0);
    end
    out_ready = 1;
    step();
    chk("t3_done", 32'(out_valid), 0);
    // 4: rotation from ptr=1
    req = 4'b0010; req_data = 32'hD3C2_B1A0;
    step();
    req = 4'b1001;
    step();
    chk("t4_win3", 32'(out_src), 3);
    step();
    chk("t4_win0", 32'(out_src), 0);
    req = 0;
    step();
    // 5: reset mid-HOLD discards operand and restores ptr
    req = 4'b0001; out_ready = 0;
    step();
    req = 0;
    step();
    rst_n = 0;
    step();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_ack", 32'(req_ack), 0);
    rst_n = 1; req = 4'b0110; out_ready = 1;
    step();
    chk("t5_win1", 32'(out_src), 1);
    req = 0;
    step();
    // 6: persistent single requester is granted every other cycle
    req = 4'b0010;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (req_ack[1]) grants++;
    end
    chk("t6_grants", 32'(grants), 4);
    req = 0;
    step();
    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      req = 4'($urandom_range(0, 15));
      req_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
